// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one slow external RAM port between the instruction
// fetch requester (m0) and the data requester (m1) of the core.
//
// Pulsed requests are latched into per-requester pending slots, arbitrated
// round-robin, and issued one at a time on the s_* port. Each s_ready is
// routed back to the requester that owns the in-flight transaction.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   mX_valid/instr/addr/wdata/wstrb  request pulse and its payload (X = 0, 1)
//   mX_rdata/ready/error         registered response, one-cycle ready pulse
//   s_valid/instr/addr/wdata/wstrb   registered one-cycle request to the RAM
//   s_rdata/s_ready              RAM response
//
// Optional build macro RAM_ARBITER_TIMEOUT_EN: a BUSY watchdog that forces
// an error completion after timeout_cycles cycles without s_ready. Without
// it BUSY waits indefinitely and mX_error is constant 0.
module ram_arbiter #(
  parameter int addr_width     = 32,
  parameter int data_width     = 32,
  parameter int timeout_cycles = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    m0_valid,
  input  logic                    m0_instr,
  input  logic [addr_width-1:0]   m0_addr,
  input  logic [data_width-1:0]   m0_wdata,
  input  logic [data_width/8-1:0] m0_wstrb,
  output logic [data_width-1:0]   m0_rdata,
  output logic                    m0_ready,
  output logic                    m0_error,
  input  logic                    m1_valid,
  input  logic                    m1_instr,
  input  logic [addr_width-1:0]   m1_addr,
  input  logic [data_width-1:0]   m1_wdata,
  input  logic [data_width/8-1:0] m1_wstrb,
  output logic [data_width-1:0]   m1_rdata,
  output logic                    m1_ready,
  output logic                    m1_error,
  output logic                    s_valid,
  output logic                    s_instr,
  output logic [addr_width-1:0]   s_addr,
  output logic [data_width-1:0]   s_wdata,
  output logic [data_width/8-1:0] s_wstrb,
  input  logic [data_width-1:0]   s_rdata,
  input  logic                    s_ready
);
  localparam int sw = data_width/8;

  typedef struct packed {
    logic                  instr;
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] wdata;
    logic [sw-1:0]         wstrb;
  } req_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nxt;
  req_t   req0, req1;
  logic   pend0, pend1;
  logic   last_grant;   // 0 = m0, 1 = m1
  logic   owner;        // requester of the in-flight transaction
  logic   gnt, gsel, done;
  logic [data_width-1:0] rsp_data;

`ifdef RAM_ARBITER_TIMEOUT_EN
  localparam int cw = $clog2(timeout_cycles + 1);
  logic [cw-1:0] cnt;
  logic          tmo;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt       = 1'b0;
    gsel      = 1'b0;
    done      = 1'b0;
    rsp_data  = s_rdata;
`ifdef RAM_ARBITER_TIMEOUT_EN
    tmo       = 1'b0;
`endif
    case (state)
      IDLE: if (pend0 || pend1) begin
        gnt       = 1'b1;
        // on a tie the requester that did not win last time goes first
        gsel      = (pend0 && pend1) ? ~last_grant : pend1;
        state_nxt = BUSY;
      end
      BUSY: begin
        if (s_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
`ifdef RAM_ARBITER_TIMEOUT_EN
        else if (cnt == cw'(timeout_cycles - 1)) begin
          done      = 1'b1;
          tmo       = 1'b1;
          rsp_data  = '0;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req0       <= '0;
      req1       <= '0;
      pend0      <= 1'b0;
      pend1      <= 1'b0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      s_valid    <= 1'b0;
      s_instr    <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_wstrb    <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_ready   <= 1'b0;
      m1_ready   <= 1'b0;
    end else begin
      s_valid  <= 1'b0;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      // a request pulse while its slot is full is dropped
      if (m0_valid && !pend0) begin
        req0  <= '{m0_instr, m0_addr, m0_wdata, m0_wstrb};
        pend0 <= 1'b1;
      end
      if (m1_valid && !pend1) begin
        req1  <= '{m1_instr, m1_addr, m1_wdata, m1_wstrb};
        pend1 <= 1'b1;
      end
      if (gnt) begin
        s_valid    <= 1'b1;
        {s_instr, s_addr, s_wdata, s_wstrb} <= gsel ? req1 : req0;
        owner      <= gsel;
        last_grant <= gsel;
      end
      // pend is only ever set while clear, so clearing here cannot collide
      if (done) begin
        if (owner) begin
          m1_ready <= 1'b1;
          m1_rdata <= rsp_data;
          pend1    <= 1'b0;
        end else begin
          m0_ready <= 1'b1;
          m0_rdata <= rsp_data;
          pend0    <= 1'b0;
        end
      end
    end
  end

`ifdef RAM_ARBITER_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      m0_error <= 1'b0;
      m1_error <= 1'b0;
    end else begin
      m0_error <= tmo && !owner;
      m1_error <= tmo && owner;
      if (gnt || tmo)                   cnt <= '0;
      else if (state == BUSY && !s_ready) cnt <= cnt + 1'b1;
    end
  end
`else
  assign m0_error = 1'b0;
  assign m1_error = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes the expected RAM
// requests and requester responses (with their expected cycle) into queues;
// a negedge monitor pops and compares whenever the DUT presents s_valid or
// mX_ready. A small RAM responder replies from its own queue of
// (latency, data) entries; latency < 0 means never answer.
module tb_ram_arbiter;
  localparam int AW = 32, DW = 32, SW = 4;

  logic clock, reset;
  logic m0_valid, m0_instr, m1_valid, m1_instr;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, s_wdata, m0_rdata, m1_rdata, s_rdata;
  logic [SW-1:0] m0_wstrb, m1_wstrb, s_wstrb;
  logic m0_ready, m0_error, m1_ready, m1_error;
  logic s_valid, s_instr, s_ready, ram_rdy, stray_rdy;

  assign s_ready = ram_rdy | stray_rdy;

  ram_arbiter #(.addr_width(AW), .data_width(DW), .timeout_cycles(16)) dut (
    .clock(clock), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m0_ready(m0_ready), .m0_error(m0_error),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .m1_ready(m1_ready), .m1_error(m1_error),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .s_ready(s_ready)
  );

  typedef struct {logic instr; logic [AW-1:0] addr; logic [DW-1:0] wdata;
                  logic [SW-1:0] wstrb; int cyc;} sexp_t;
  typedef struct {logic [DW-1:0] rdata; logic err; int cyc;} rexp_t;
  typedef struct {int lat; logic [DW-1:0] data;} ram_t;

  sexp_t sq[$];
  rexp_t r0q[$], r1q[$];
  ram_t  ramq[$];
  int total = 0, bad = 0, cyc = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // RAM responder
  initial begin
    ram_t r;
    ram_rdy = 1'b0;
    s_rdata = '0;
    forever begin
      @(negedge clock);
      if (s_valid && ramq.size() > 0) begin
        r = ramq.pop_front();
        if (r.lat >= 0) begin
          repeat (r.lat) @(negedge clock);
          s_rdata = r.data;
          ram_rdy = 1'b1;
          @(negedge clock);
          ram_rdy = 1'b0;
        end
      end
    end
  end

  task automatic rsp_chk(input int m, input logic [DW-1:0] rd, input logic er);
    rexp_t e;
    total++;
    if ((m == 0 && r0q.size() == 0) || (m == 1 && r1q.size() == 0)) begin
      bad++;
      $display("FAIL m%0d_ready unexpected at cyc %0d rdata=%h", m, cyc, rd);
    end else begin
      e = (m == 0) ? r0q.pop_front() : r1q.pop_front();
      if (rd !== e.rdata || er !== e.err || cyc != e.cyc) begin
        bad++;
        $display("FAIL m%0d_rsp got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                 m, rd, er, cyc, e.rdata, e.err, e.cyc);
      end
    end
  endtask

  // monitor
  always @(negedge clock) begin
    sexp_t e;
    if (s_valid) begin
      total++;
      if (sq.size() == 0) begin
        bad++;
        $display("FAIL s_req unexpected at cyc %0d addr=%h", cyc, s_addr);
      end else begin
        e = sq.pop_front();
        if (s_instr !== e.instr || s_addr !== e.addr || s_wdata !== e.wdata ||
            s_wstrb !== e.wstrb || cyc != e.cyc) begin
          bad++;
          $display("FAIL s_req got i=%b a=%h w=%h s=%h cyc=%0d want i=%b a=%h w=%h s=%h cyc=%0d",
                   s_instr, s_addr, s_wdata, s_wstrb, cyc,
                   e.instr, e.addr, e.wdata, e.wstrb, e.cyc);
        end
      end
    end
    if (m0_ready) rsp_chk(0, m0_rdata, m0_error);
    if (m1_ready) rsp_chk(1, m1_rdata, m1_error);
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask
  task automatic settle(input int n);
    repeat (n) tick();
  endtask
  task automatic set_req(input int m, input logic ins, input logic [AW-1:0] a,
                         input logic [DW-1:0] w, input logic [SW-1:0] st);
    if (m == 0) begin
      m0_valid = 1'b1; m0_instr = ins; m0_addr = a; m0_wdata = w; m0_wstrb = st;
    end else begin
      m1_valid = 1'b1; m1_instr = ins; m1_addr = a; m1_wdata = w; m1_wstrb = st;
    end
  endtask
  task automatic clr();
    m0_valid = 1'b0; m1_valid = 1'b0;
  endtask
  task automatic exp_s(input logic ins, input logic [AW-1:0] a, input logic [DW-1:0] w,
                       input logic [SW-1:0] st, input int c);
    sexp_t e;
    e.instr = ins; e.addr = a; e.wdata = w; e.wstrb = st; e.cyc = c;
    sq.push_back(e);
  endtask
  task automatic exp_r(input int m, input logic [DW-1:0] d, input logic er, input int c);
    rexp_t e;
    e.rdata = d; e.err = er; e.cyc = c;
    if (m == 0) r0q.push_back(e); else r1q.push_back(e);
  endtask
  task automatic ram(input int lat, input logic [DW-1:0] d);
    ram_t r;
    r.lat = lat; r.data = d;
    ramq.push_back(r);
  endtask
  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " s_valid"}, DW'(s_valid), '0);
    chk({tag, " s_instr"}, DW'(s_instr), '0);
    chk({tag, " s_addr"}, s_addr, '0);
    chk({tag, " s_wdata"}, s_wdata, '0);
    chk({tag, " s_wstrb"}, DW'(s_wstrb), '0);
    chk({tag, " m0_rdata"}, m0_rdata, '0);
    chk({tag, " m1_rdata"}, m1_rdata, '0);
    chk({tag, " readys"}, DW'({m0_ready, m1_ready}), '0);
    chk({tag, " errors"}, DW'({m0_error, m1_error}), '0);
  endtask

  initial begin
    int c;
    reset = 1'b1; stray_rdy = 1'b0;
    m0_valid = 0; m0_instr = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 0; m1_instr = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    settle(3);
    chk_zero("reset");
    reset = 1'b0;
    tick();

    // simultaneous requests after reset: m0 wins the tie
    c = cyc;
    ram(0, 32'h1111_0000); ram(0, 32'h2222_0000);
    set_req(0, 1'b1, 32'h8000_0100, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h8000_0200, 32'hAAAA_5555, 4'hF);
    exp_s(1'b1, 32'h8000_0100, 32'h0, 4'h0, c + 2);
    exp_r(0, 32'h1111_0000, 1'b0, c + 3);
    exp_s(1'b0, 32'h8000_0200, 32'hAAAA_5555, 4'hF, c + 4);
    exp_r(1, 32'h2222_0000, 1'b0, c + 5);
    tick(); clr(); settle(8);

    // single m0 read, zero-wait RAM
    c = cyc;
    ram(0, 32'hDEAD_BEEF);
    set_req(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
    exp_s(1'b0, 32'h8000_0010, 32'h0, 4'h0, c + 2);
    exp_r(0, 32'hDEAD_BEEF, 1'b0, c + 3);
    tick(); clr(); settle(6);
    chk("m0_rdata hold", m0_rdata, 32'hDEAD_BEEF);

    // both again after an m0 grant: m1 goes first
    c = cyc;
    ram(0, 32'h3333_3333); ram(1, 32'h4444_4444);
    set_req(0, 1'b0, 32'h8000_0020, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h8000_0030, 32'h0, 4'h0);
    exp_s(1'b0, 32'h8000_0030, 32'h0, 4'h0, c + 2);
    exp_r(1, 32'h3333_3333, 1'b0, c + 3);
    exp_s(1'b0, 32'h8000_0020, 32'h0, 4'h0, c + 4);
    exp_r(0, 32'h4444_4444, 1'b0, c + 6);
    tick(); clr(); settle(10);

    // m1 write passthrough, 5-cycle RAM
    c = cyc;
    ram(5, 32'hA5A5_A5A5);
    set_req(1, 1'b0, 32'h8000_0004, 32'h1234_5678, 4'b0011);
    exp_s(1'b0, 32'h8000_0004, 32'h1234_5678, 4'b0011, c + 2);
    exp_r(1, 32'hA5A5_A5A5, 1'b0, c + 8);
    tick(); clr(); settle(12);

    // re-pulse while pending: second address dropped
    c = cyc;
    ram(0, 32'h5555_5555);
    set_req(0, 1'b0, 32'h8000_0040, 32'h0, 4'h0);
    exp_s(1'b0, 32'h8000_0040, 32'h0, 4'h0, c + 2);
    exp_r(0, 32'h5555_5555, 1'b0, c + 3);
    tick();
    set_req(0, 1'b0, 32'h8000_0044, 32'h0, 4'h0);
    tick(); clr(); settle(6);

    // stray s_ready in IDLE
    stray_rdy = 1'b1; tick(); stray_rdy = 1'b0; settle(3);
    chk("stray m0_rdata", m0_rdata, 32'h5555_5555);
    chk("stray m1_rdata", m1_rdata, 32'hA5A5_A5A5);
    chk("stray s_addr", s_addr, 32'h8000_0040);

    // reset while BUSY, late s_ready afterwards
    c = cyc;
    set_req(0, 1'b0, 32'h8000_0050, 32'h0, 4'h0);
    exp_s(1'b0, 32'h8000_0050, 32'h0, 4'h0, c + 2);
    tick(); clr(); settle(2);
    reset = 1'b1; settle(2); reset = 1'b0;
    settle(2);
    stray_rdy = 1'b1; tick(); stray_rdy = 1'b0; settle(4);
    chk_zero("post-reset");

`ifdef RAM_ARBITER_TIMEOUT_EN
    // RAM never answers m0: forced error completion, then m1 proceeds
    c = cyc;
    ram(-1, 32'h0); ram(0, 32'h6666_6666);
    set_req(0, 1'b0, 32'h8000_0060, 32'h0, 4'h0);
    exp_s(1'b0, 32'h8000_0060, 32'h0, 4'h0, c + 2);
    exp_r(0, 32'h0, 1'b1, c + 18);
    tick(); clr();
    set_req(1, 1'b0, 32'h8000_0070, 32'h0, 4'h0);
    exp_s(1'b0, 32'h8000_0070, 32'h0, 4'h0, c + 19);
    exp_r(1, 32'h6666_6666, 1'b0, c + 20);
    tick(); clr(); settle(26);
`endif

    for (int i = 0; i < 50 && (sq.size() + r0q.size() + r1q.size()) != 0; i++) tick();
    chk("leftover expectations", DW'(sq.size() + r0q.size() + r1q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single slow external RAM port (ram_base_addr..ram_top_addr window) between the instruction-fetch and data requesters of the core.
- Latches pulsed requests and arbitrates them round-robin.
- Issues one transaction at a time to the RAM controller and routes each response back to the requester that owns it.
- Sits between the core memory ports and the RAM model/controller, which runs on the clk_divider_ram-derived slow clock enable.

Parameters:
- addr_width, 32, address bus width.
- data_width, 32, data bus width; strobe width is data_width/8.
- timeout_cycles, 1024, cycles in BUSY without s_ready before forced completion (used only with the optional feature).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- m0_valid  input  1  instruction requester: request pulse
- m0_instr  input  1  instruction-fetch flag
- m0_addr  input  addr_width  request address
- m0_wdata  input  data_width  write data
- m0_wstrb  input  data_width/8  byte write strobes; all zero means read
- m0_rdata  output  data_width  read data
- m0_ready  output  1  completion pulse
- m0_error  output  1  timeout completion flag
- m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_ready, m1_error: data requester, same widths and meanings as m0_*
- s_valid  output  1  RAM request pulse
- s_instr  output  1  forwarded instr flag
- s_addr  output  addr_width  forwarded address
- s_wdata  output  data_width  forwarded write data
- s_wstrb  output  data_width/8  forwarded strobes
- s_rdata  input  data_width  RAM read data
- s_ready  input  1  RAM completion pulse

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`.
- Reset values:
  - all outputs 0; state IDLE; both pending flags 0; last_grant = m1, so m0 wins the first tie; timeout counter 0.
  - reset mid-transaction: drops all pending and in-flight work; a later s_ready is ignored because state is IDLE.
- Capture:
  - mX_valid high at edge k while pendX = 0 → addr/wdata/wstrb/instr latched, pendX = 1 from cycle k+1.
  - mX_valid while pendX = 1 → ignored (protocol violation; request not queued).
- Grant (IDLE, at least one pend set, evaluated in cycle c):
  - only one pending → grant it;
  - both pending → grant the requester that is not last_grant;
  - update last_grant; state → BUSY.
  - s_valid, s_addr, s_wdata, s_wstrb, s_instr are registered: s_valid is high for exactly one cycle, c+1.
  - latency: request at edge k → s_valid in cycle k+2 (capture cycle k+1, grant evaluated at k+1, s_valid at k+2).
  - s_addr, s_wdata, s_wstrb, s_instr hold the granted values until the next grant.
- Completion (BUSY): s_ready high in cycle j, including j equal to the s_valid cycle for zero-wait RAM.
  - owner's mX_rdata = s_rdata (registered), mX_ready high in cycle j+1 only, mX_error = 0.
  - owner's pend cleared at edge j; state → IDLE; the other requester is granted no earlier than s_valid in cycle j+2.
  - mX_rdata holds its value until the owner's next completion.
- New request on ready: mX_valid coincident with own mX_ready is captured normally, since pend was already cleared.
- Stray s_ready: s_ready in IDLE is ignored.
- Fairness: under continuous contention, grants alternate m0, m1, m0, …; no requester waits more than one transaction.
- Read/write: the arbiter does not decode writes; wstrb passes through unchanged. rdata is returned for writes too, and requesters ignore it.

Optional Feature:
- Macro: RAM_ARBITER_TIMEOUT_EN.
- Defined:
  - a counter increments each BUSY cycle without s_ready.
  - reaching timeout_cycles forces completion: owner mX_ready = 1 and mX_error = 1 for one cycle, mX_rdata = 0; pend cleared; state → IDLE; counter cleared.
  - a late s_ready afterwards is ignored only if it arrives while IDLE.
  - counter clears on every grant.
- Undefined: no counter logic; BUSY waits indefinitely; m0_error and m1_error are tied to 0.

Test Plan:
- Single m0 read:
  - stimulus: m0_valid at edge 0, addr 0x80000010; RAM answers s_ready in the s_valid cycle with 0xDEADBEEF.
  - response: s_valid in cycle 2 with s_addr 0x80000010; m0_ready in cycle 3 with m0_rdata 0xDEADBEEF; m1_ready stays 0.
- Simultaneous requests after reset:
  - stimulus: m0 and m1 valid in the same cycle.
  - response: m0 granted first; m1's s_valid two cycles after m0's s_ready.
  - follow-up: both request again → m1 granted first (round-robin).
- Write passthrough:
  - stimulus: m1 write, addr 0x80000004, wdata 0x12345678, wstrb 0b0011.
  - response: identical values on s_*; m1_ready pulses once after a 5-cycle RAM delay.
- Reset mid-operation:
  - stimulus: assert reset while BUSY, then s_ready 2 cycles after reset release.
  - response: no mX_ready, no s_valid, all outputs 0.
- Protocol edge cases:
  - stimulus 1: m0_valid re-pulsed while pend0 = 1 with a different address → second request dropped; exactly one s_valid, carrying the first address.
  - stimulus 2: s_ready pulsed in IDLE → no output change.
- Timeout (RAM_ARBITER_TIMEOUT_EN defined, timeout_cycles = 16):
  - stimulus: RAM never answers.
  - response: m0_ready = 1, m0_error = 1, m0_rdata = 0 exactly 16 BUSY cycles after the grant; the next pending request is then granted.
